load_store_unit: RTL

Memory-stage load/store unit placed directly upstream of the byte-addressed, big-endian data memory. Accepts one load or store request at a time from the pipeline and checks alignment. Issues word-aligned accesses to the memory. Sub-word stores become a read-modify-write sequence, and sub-word load data is extracted and sign- or zero-extended.

---
 rtl/load_store_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit in front of a big-endian, word-organised data memory.
// Sub-word stores are read-modify-write; sub-word loads are lane-extracted and extended.
module load_store_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        mem_write
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    READ   = 3'd2,
    MERGE  = 3'd3,
    RESP   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        write_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;
  logic        error_q;

  logic        accept;
  logic        req_err;
  logic [1:0]  offset;
  logic [4:0]  byte_shamt;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;
  logic [31:0] lane_mask;
  logic [31:0] lane_ins;
  logic [31:0] merged;

  assign accept  = req_valid && (state_q == IDLE);
  assign req_err = (req_size == 2'b11) ||
                   ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  // Byte o sits at bit 31-8o, so the right-shift distance is 8*(3-o) = {~o,3'b0}.
  assign offset     = addr_q[1:0];
  assign byte_shamt = {~offset, 3'b000};

  always_comb begin
    load_byte = 8'(mem_read_data >> byte_shamt);
    load_half = offset[1] ? mem_read_data[15:0] : mem_read_data[31:16];
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'd0, load_byte} : {{24{load_byte[7]}}, load_byte};
      2'b01:   load_ext = uns_q ? {16'd0, load_half} : {{16{load_half[15]}}, load_half};
      default: load_ext = mem_read_data;
    endcase
  end

  always_comb begin
    if (size_q == 2'b00) begin
      lane_mask = 32'h0000_00FF << byte_shamt;
      lane_ins  = {4{wdata_q[7:0]}};
    end else begin
      lane_mask = offset[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
      lane_ins  = {2{wdata_q[15:0]}};
    end
    merged = (merge_q & ~lane_mask) | (lane_ins & lane_mask);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      merge_q <= 32'd0;
      rdata_q <= 32'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q <= req_write;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rdata_q <= 32'd0;
        error_q <= req_err;
      end
      if ((state_q == ACCESS) && !write_q) rdata_q <= load_ext;
      if (state_q == READ) merge_q <= mem_read_data;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                            state_d = RESP;
          else if (!req_write || req_size == 2'b10) state_d = ACCESS;
          else                                    state_d = READ;
        end
      end
      ACCESS:  state_d = RESP;
      READ:    state_d = MERGE;
      MERGE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready      = (state_q == IDLE);
    resp_valid     = (state_q == RESP);
    mem_write      = 1'b0;
    mem_write_data = 32'd0;
    if ((state_q == ACCESS) && write_q) begin
      mem_write      = 1'b1;
      mem_write_data = wdata_q;
    end else if (state_q == MERGE) begin
      mem_write      = 1'b1;
      mem_write_data = merged;
    end
  end

  assign mem_address = {addr_q[31:2], 2'b00};
  assign resp_rdata  = rdata_q;
  assign resp_error  = error_q;

endmodule
